// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: function codes, frame sync nibble, FSM states.
// Latency: n/a (types, constants and a pure header-check function only).
// Backpressure: n/a.
package alu_pkg;

    // ALU function encodings carried in the low two bits of the frame header
    localparam logic [1:0] FUN_ADD = 2'd0;
    localparam logic [1:0] FUN_SUB = 2'd1;
    localparam logic [1:0] FUN_AND = 2'd2;
    localparam logic [1:0] FUN_OR  = 2'd3;

    // Upper nibble every valid header must carry
    localparam logic [3:0] HDR_SYNC = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GET_A = 2'd1,
        ST_GET_B = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    // Header is {HDR_SYNC, 2'b00, fun}; the two reserved bits must be zero
    function automatic logic hdr_ok(input logic [7:0] hdr);
        return (hdr[7:4] == HDR_SYNC) && (hdr[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects NB = WIDTH/8 bytes LS-first into a shadow register; data_o already includes this cycle's byte.
// Latency: combinational view of the insert, stored on the next clock; done_o flags the last byte.
// Backpressure: none; the caller gates we_i with its own transfer condition.
// Ports: clk_i/rst_i (sync, active-high); clr_i rewinds the byte index; we_i/byte_i insert a byte;
//        data_o assembled value (with pending insert); done_o high when this insert fills the top byte.
module byte_assembler
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] data_o,
    output logic             done_o
);

    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(NB) + 1;

    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] data_q;

    // Exposing the post-insert value lets the owner capture a complete operand
    // on the same edge that accepts its final byte.
    always_comb begin
        data_o = data_q;
        for (int i = 0; i < NB; i++) begin
            if (we_i && (idx_q == IW'(i))) begin
                data_o[8*i +: 8] = byte_i;
            end
        end
    end

    assign done_o = we_i && (idx_q == IW'(NB - 1));

    // Index saturates on the last byte; the owner clears it on every state change.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (we_i && !done_o) begin
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_o;
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles byte-serial {header, A bytes, B bytes} frames into ALU operands; flags bad headers and stalls.
// Latency: op_valid_o rises the cycle after the last B byte; one op per 2*NB+2 cycles at best.
// Backpressure: rx_ready_o drops while an op waits in ISSUE; the ALU may hold op_ready_i low indefinitely.
// Ports: clk_i, rst_i (sync, active-high); rx_data_i/rx_valid_i/rx_ready_o byte stream in;
//        a_o, b_o, alu_fun_o, op_valid_o/op_ready_i operand handshake out; frame_err_o one-cycle error pulse.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [1:0]       alu_fun_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic             frame_err_o
);

    state_t           state_q, state_d;
    logic             rx_ready_q, op_valid_q, frame_err_q, frame_err_d;
    logic [WIDTH-1:0] a_q, b_q, a_asm, b_asm;
    logic [1:0]       fun_q, fun_sh_q, fun_sh_d;
    logic [7:0]       to_q, to_d;
    logic             xfer, accept, in_get, to_hit, state_chg;
    logic             a_we, b_we, a_done, b_done;

    assign xfer      = rx_valid_i && rx_ready_q;
    assign accept    = op_valid_q && op_ready_i;
    assign in_get    = (state_q == ST_GET_A) || (state_q == ST_GET_B);
    // An idle cycle at TIMEOUT-1 is the one that brings the count to TIMEOUT;
    // a byte arriving on that same cycle takes priority.
    assign to_hit    = in_get && !xfer && (to_q == 8'(TIMEOUT - 1));
    assign a_we      = xfer && (state_q == ST_GET_A);
    assign b_we      = xfer && (state_q == ST_GET_B);
    assign state_chg = (state_d != state_q);

    byte_assembler #(.WIDTH(WIDTH)) u_asm_a (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_chg),
        .we_i   (a_we),
        .byte_i (rx_data_i),
        .data_o (a_asm),
        .done_o (a_done)
    );

    byte_assembler #(.WIDTH(WIDTH)) u_asm_b (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_chg),
        .we_i   (b_we),
        .byte_i (rx_data_i),
        .data_o (b_asm),
        .done_o (b_done)
    );

    always_comb begin
        state_d     = state_q;
        frame_err_d = 1'b0;
        fun_sh_d    = fun_sh_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (hdr_ok(rx_data_i)) begin
                        state_d  = ST_GET_A;
                        fun_sh_d = rx_data_i[1:0];
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (to_hit) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (a_done) begin
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (to_hit) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (b_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        to_d = '0;
        if (in_get && !xfer && !state_chg) begin
            to_d = to_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rx_ready_q  <= 1'b1;
            op_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            fun_sh_q    <= '0;
            to_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= (state_d != ST_ISSUE);
            op_valid_q  <= (state_d == ST_ISSUE);
            frame_err_q <= frame_err_d;
            fun_sh_q    <= fun_sh_d;
            to_q        <= to_d;
            // Visible operands change only when a whole frame lands
            if ((state_q == ST_GET_B) && (state_d == ST_ISSUE)) begin
                a_q   <= a_asm;
                b_q   <= b_asm;
                fun_q <= fun_sh_q;
            end
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign op_valid_o  = op_valid_q;
    assign frame_err_o = frame_err_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign alu_fun_o   = fun_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader at WIDTH=16, TIMEOUT=8.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: op_ready driven per scenario.
module tb_alu_operand_loader;
    import alu_pkg::*;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [WIDTH-1:0] a, b;
    logic [1:0]       fun;
    logic             op_valid;
    logic             op_ready = 1'b1;
    logic             frame_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_operand_loader #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready),
        .a_o         (a),
        .b_o         (b),
        .alu_fun_o   (fun),
        .op_valid_o  (op_valid),
        .op_ready_i  (op_ready),
        .frame_err_o (frame_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; op_ready = 1'b1;
        step(); step();
        n_chk++;
        if ({a, b, fun, op_valid, frame_err, rx_ready} !== {16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: a=%h b=%h fun=%0d vld=%b err=%b rdy=%b want 0 0 0 0 0 1",
                     a, b, fun, op_valid, frame_err, rx_ready);
        end
        rst = 1'b0;
        step();
        n_chk++;
        if (rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_rdy: rx_ready=%b want 1", rx_ready);
        end
    endtask

    task automatic test_basic();
        op_ready = 1'b1;
        drive(8'hA1); drive(8'h34); drive(8'h12); drive(8'h78);
        n_chk++;
        if (op_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early: op_valid=%b want 0", op_valid);
        end
        drive(8'h56);
        rx_valid = 1'b0;
        n_chk++;
        if ({op_valid, rx_ready, a, b, fun} !== {1'b1, 1'b0, 16'h1234, 16'h5678, FUN_SUB}) begin
            n_fail++;
            $display("FAIL basic_op: vld=%b rdy=%b a=%h b=%h fun=%0d want 1 0 1234 5678 1",
                     op_valid, rx_ready, a, b, fun);
        end
        step();
        n_chk++;
        if ({op_valid, rx_ready, a, b} !== {1'b0, 1'b1, 16'h1234, 16'h5678}) begin
            n_fail++;
            $display("FAIL basic_accept: vld=%b rdy=%b a=%h b=%h want 0 1 1234 5678",
                     op_valid, rx_ready, a, b);
        end
    endtask

    task automatic test_stall();
        op_ready = 1'b0;
        drive(8'hA1); drive(8'h34); drive(8'h12); drive(8'h78); drive(8'h56);
        rx_data = 8'h52;   // stays valid while stalled; must not be taken
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if ({op_valid, rx_ready, frame_err, a, b, fun} !==
                {1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, FUN_SUB}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: vld=%b rdy=%b err=%b a=%h b=%h fun=%0d want 1 0 0 1234 5678 1",
                         i, op_valid, rx_ready, frame_err, a, b, fun);
            end
            step();
        end
        op_ready = 1'b1; rx_valid = 1'b0;
        step();
        n_chk++;
        if ({op_valid, rx_ready, frame_err} !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_release: vld=%b rdy=%b err=%b want 0 1 0", op_valid, rx_ready, frame_err);
        end
    endtask

    task automatic test_bad_header();
        op_ready = 1'b1;
        drive(8'h52);
        n_chk++;
        if ({frame_err, rx_ready} !== 2'b11) begin
            n_fail++; $display("FAIL badhdr_pulse: err=%b rdy=%b want 1 1", frame_err, rx_ready);
        end
        drive(8'h13);
        n_chk++;
        if (frame_err !== 1'b1) begin
            n_fail++; $display("FAIL badhdr_b2b: err=%b want 1", frame_err);
        end
        drive(8'hA3);
        n_chk++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL badhdr_single: err=%b want 0", frame_err);
        end
        drive(8'hFF); drive(8'hFF); drive(8'h01); drive(8'h00);
        rx_valid = 1'b0;
        n_chk++;
        if ({op_valid, a, b, fun} !== {1'b1, 16'hFFFF, 16'h0001, FUN_OR}) begin
            n_fail++;
            $display("FAIL badhdr_next: vld=%b a=%h b=%h fun=%0d want 1 ffff 0001 3", op_valid, a, b, fun);
        end
        step();
    endtask

    task automatic test_timeout();
        op_ready = 1'b1;
        // Gap of TIMEOUT idle cycles: frame dropped
        drive(8'hA2); drive(8'h11);
        rx_valid = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            n_chk++;
            if (frame_err !== 1'b0) begin
                n_fail++; $display("FAIL timeout_early[%0d]: err=%b want 0", i, frame_err);
            end
        end
        step();
        n_chk++;
        if (frame_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_pulse: err=%b want 1", frame_err);
        end
        step();
        n_chk++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_single: err=%b want 0", frame_err);
        end
        drive(8'hA0); drive(8'h01); drive(8'h00); drive(8'h02); drive(8'h00);
        rx_valid = 1'b0;
        n_chk++;
        if ({op_valid, a, b, fun} !== {1'b1, 16'h0001, 16'h0002, FUN_ADD}) begin
            n_fail++;
            $display("FAIL timeout_drop: vld=%b a=%h b=%h fun=%0d want 1 0001 0002 0", op_valid, a, b, fun);
        end
        step();
        // Gap of TIMEOUT-1 idle cycles: byte on the boundary cycle wins
        drive(8'hA2); drive(8'h11);
        rx_valid = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) step();
        drive(8'h22);
        n_chk++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_edge: err=%b want 0", frame_err);
        end
        drive(8'h33); drive(8'h44);
        rx_valid = 1'b0;
        n_chk++;
        if ({op_valid, frame_err, a, b, fun} !== {1'b1, 1'b0, 16'h2211, 16'h4433, FUN_AND}) begin
            n_fail++;
            $display("FAIL timeout_gap7: vld=%b err=%b a=%h b=%h fun=%0d want 1 0 2211 4433 2",
                     op_valid, frame_err, a, b, fun);
        end
        step();
    endtask

    task automatic test_reset_midframe();
        op_ready = 1'b1;
        drive(8'hA0); drive(8'hAA); drive(8'hBB);
        rx_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++;
        if ({a, b, fun, op_valid, frame_err, rx_ready} !== {16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid: a=%h b=%h fun=%0d vld=%b err=%b rdy=%b want 0 0 0 0 0 1",
                     a, b, fun, op_valid, frame_err, rx_ready);
        end
        step();
        n_chk++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_noerr: err=%b want 0", frame_err);
        end
        drive(8'hA1); drive(8'h01); drive(8'h02); drive(8'h03); drive(8'h04);
        rx_valid = 1'b0;
        n_chk++;
        if ({op_valid, a, b, fun} !== {1'b1, 16'h0201, 16'h0403, FUN_SUB}) begin
            n_fail++;
            $display("FAIL rst_mid_next: vld=%b a=%h b=%h fun=%0d want 1 0201 0403 1", op_valid, a, b, fun);
        end
        step();
        // Reset while an op is pending in ISSUE
        op_ready = 1'b0;
        drive(8'hA2); drive(8'h05); drive(8'h06); drive(8'h07); drive(8'h08);
        rx_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; op_ready = 1'b1;
        step();
        n_chk++;
        if ({op_valid, frame_err, rx_ready, a} !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
            n_fail++;
            $display("FAIL rst_issue: vld=%b err=%b rdy=%b a=%h want 0 0 1 0000", op_valid, frame_err, rx_ready, a);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea, eb;
        logic [1:0]  ef;
        logic [7:0]  hdr;
        logic        err_seen, early_seen;
        int          last_cyc;
        op_ready   = 1'b1;
        err_seen   = 1'b0;
        early_seen = 1'b0;
        last_cyc   = 0;
        for (int f = 0; f < 20; f++) begin
            ef  = 2'($urandom_range(0, 3));
            ea  = 16'($urandom_range(0, 65535));
            eb  = 16'($urandom_range(0, 65535));
            hdr = {HDR_SYNC, 2'b00, ef};
            drive(hdr);      err_seen |= frame_err; early_seen |= op_valid;
            drive(ea[7:0]);  err_seen |= frame_err; early_seen |= op_valid;
            drive(ea[15:8]); err_seen |= frame_err; early_seen |= op_valid;
            drive(eb[7:0]);  err_seen |= frame_err; early_seen |= op_valid;
            drive(eb[15:8]); err_seen |= frame_err;
            n_chk++;
            if ({op_valid, rx_ready, a, b, fun} !== {1'b1, 1'b0, ea, eb, ef}) begin
                n_fail++;
                $display("FAIL b2b_op[%0d]: vld=%b rdy=%b a=%h b=%h fun=%0d want 1 0 %h %h %0d",
                         f, op_valid, rx_ready, a, b, fun, ea, eb, ef);
            end
            if (f > 0) begin
                n_chk++;
                if (cyc - last_cyc !== 6) begin
                    n_fail++; $display("FAIL b2b_rate[%0d]: spacing=%0d want 6", f, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            rx_data = 8'h52;   // held valid during ISSUE; must be ignored
            step();
            err_seen |= frame_err;
        end
        rx_valid = 1'b0;
        step();
        err_seen |= frame_err;
        n_chk++;
        if ({err_seen, early_seen} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_clean: err_seen=%b early_valid=%b want 0 0", err_seen, early_seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bad_header();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
